check_ins_unit: RTL and testbench

// - Instruction checker and PC-source selector between fetch and the control unit (CU).
// - Classifies each fetched instruction as normal, control-flow or communication, registers it towards the CU, and stalls for pipeline drain after control flow.
// - Raises a communication request and drives the fetch PC-select mux (pc_in_0 sequential / pc_in_1 redirect).

---
 rtl/check_ins_pkg.sv | 38 +++
 rtl/check_ins_unit_pc_mux2.sv | 13 +
 rtl/check_ins_unit.sv | 129 ++++++++++++
 tb/tb_check_ins_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/check_ins_pkg.sv
// Shared opcode constants, state encoding and instruction classifier
// for the instruction checker.
package check_ins_pkg;

    localparam logic [5:0]  OPC_COMM    = 6'h3F;
    localparam logic [5:0]  OPC_CTRL_LO = 6'h02;
    localparam logic [5:0]  OPC_CTRL_HI = 6'h07;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

    typedef enum logic {
        RUN,
        STALL
    } state_e;

    typedef enum logic [1:0] {
        CLS_NOP,
        CLS_NORMAL,
        CLS_CTRL,
        CLS_COMM
    } ins_class_e;

    function automatic ins_class_e classify(
        input logic [5:0] opcode,
        input logic       is_zero
    );
        ins_class_e cls;
        cls = CLS_NORMAL;
        unique case (1'b1)
            is_zero:                 cls = CLS_NOP;
            (opcode == OPC_COMM):    cls = CLS_COMM;
            (opcode >= OPC_CTRL_LO
             && opcode <= OPC_CTRL_HI): cls = CLS_CTRL;
            default:                 cls = CLS_NORMAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/check_ins_unit_pc_mux2.sv
// Two-input combinational selector used for the fetch PC source.
module pc_mux2 #(
    parameter int width = 32
) (
    input  logic [width-1:0] in_0,
    input  logic [width-1:0] in_1,
    input  logic             signal,
    output logic [width-1:0] out
);

    assign out = signal ? in_1 : in_0;

endmodule

// File: rtl/check_ins_unit.sv
// Classifies fetched instructions, forwards them to the CU, stalls
// for pipeline drain after control flow and selects the next PC.
module check_ins_unit
    import check_ins_pkg::*;
#(
    parameter int bus_width = 32,
    parameter int phases    = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [bus_width-1:0] ins_in,
    input  logic                 wait_for_next_in,
    input  logic [bus_width-1:0] pc_in_0,
    input  logic [bus_width-1:0] pc_in_1,
    output logic [bus_width-1:0] pc_out,
    output logic [bus_width-1:0] ins_out,
    output logic [18:0]          signal_out,
    output logic                 pc_choice_out,
    output logic                 cu_enable_out,
    output logic                 communication_enable_out
);

    localparam int CW = (phases < 2) ? 1 : $clog2(phases + 1);
    localparam logic [CW-1:0] CNT_INIT =
        (phases < 2) ? '0 : CW'(phases - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [bus_width-1:0] ins_q, ins_d;
    logic [18:0]          sig_q, sig_d;
    logic                 pcsel_q, pcsel_d;
    logic                 cu_q, cu_d;
    logic                 comm_q, comm_d;
    ins_class_e           cls;

    assign cls = classify(ins_in[31:26], ins_in == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ins_q   <= '0;
            sig_q   <= '0;
            pcsel_q <= 1'b0;
            cu_q    <= 1'b0;
            comm_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ins_q   <= ins_d;
            sig_q   <= sig_d;
            pcsel_q <= pcsel_d;
            cu_q    <= cu_d;
            comm_q  <= comm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!wait_for_next_in) begin
            unique case (state_q)
                RUN: begin
                    if (cls == CLS_CTRL && phases > 1) begin
                        state_d = STALL;
                        cnt_d   = CNT_INIT;
                    end
                end
                STALL: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q <= 1) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        ins_d   = ins_q;
        sig_d   = sig_q;
        pcsel_d = 1'b0;
        cu_d    = 1'b0;
        comm_d  = 1'b0;
        if (!wait_for_next_in) begin
            unique case (state_q)
                RUN: begin
                    unique case (cls)
                        CLS_NOP: ins_d = '0;
                        CLS_NORMAL: begin
                            ins_d = ins_in;
                            cu_d  = 1'b1;
                        end
                        CLS_COMM: begin
                            ins_d  = '0;
                            sig_d  = ins_in[18:0];
                            comm_d = 1'b1;
                        end
                        CLS_CTRL: begin
                            ins_d   = ins_in;
                            cu_d    = 1'b1;
                            // no drain window: redirect right away
                            pcsel_d = (phases <= 1);
                        end
                        default: ins_d = '0;
                    endcase
                end
                STALL: begin
                    ins_d   = '0;
                    pcsel_d = (cnt_q == 1);
                end
                default: ins_d = '0;
            endcase
        end
    end

    assign ins_out                  = ins_q;
    assign signal_out               = sig_q;
    assign pc_choice_out            = pcsel_q;
    assign cu_enable_out            = cu_q;
    assign communication_enable_out = comm_q;

    pc_mux2 #(.width(bus_width)) u_pc_mux (
        .in_0  (pc_in_0),
        .in_1  (pc_in_1),
        .signal(pc_choice_out),
        .out   (pc_out)
    );

endmodule

// File: tb/tb_check_ins_unit.sv
// Directed bench for check_ins_unit with phases=5.
module tb_check_ins_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] ins_in;
    logic        wait_for_next_in;
    logic [31:0] pc_in_0;
    logic [31:0] pc_in_1;
    logic [31:0] pc_out;
    logic [31:0] ins_out;
    logic [18:0] signal_out;
    logic        pc_choice_out;
    logic        cu_enable_out;
    logic        communication_enable_out;

    int checks   = 0;
    int failures = 0;

    check_ins_unit #(.bus_width(32), .phases(5)) dut (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .ins_in                  (ins_in),
        .wait_for_next_in        (wait_for_next_in),
        .pc_in_0                 (pc_in_0),
        .pc_in_1                 (pc_in_1),
        .pc_out                  (pc_out),
        .ins_out                 (ins_out),
        .signal_out              (signal_out),
        .pc_choice_out           (pc_choice_out),
        .cu_enable_out           (cu_enable_out),
        .communication_enable_out(communication_enable_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] ins,
                           input logic cu, input logic comm,
                           input logic pcs);
        chk({tag, ".ins"}, ins_out, ins);
        chk({tag, ".cu"}, {31'd0, cu_enable_out}, {31'd0, cu});
        chk({tag, ".comm"}, {31'd0, communication_enable_out},
            {31'd0, comm});
        chk({tag, ".pcsel"}, {31'd0, pc_choice_out}, {31'd0, pcs});
        chk({tag, ".pc"}, pc_out, pcs ? 32'h0000_0200 : 32'h0000_0100);
    endtask

    initial begin
        reset_n          = 1'b1;
        ins_in           = 32'h0400_0001;
        wait_for_next_in = 1'b0;
        pc_in_0          = 32'h0000_0100;
        pc_in_1          = 32'h0000_0200;
        step();
        step();
        // asynchronous reset mid-run
        reset_n = 1'b0;
        #1;
        chk_out("rst", 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst.sig", {13'd0, signal_out}, 32'h0);
        step();
        reset_n = 1'b1;

        ins_in = 32'h0400_0001;
        step();
        chk_out("normal", 32'h0400_0001, 1'b1, 1'b0, 1'b0);

        ins_in = 32'h0000_0000;
        step();
        chk_out("nop", 32'h0, 1'b0, 1'b0, 1'b0);

        ins_in = 32'hFC01_2345;
        step();
        chk_out("comm", 32'h0, 1'b0, 1'b1, 1'b0);
        chk("comm.sig", {13'd0, signal_out}, 32'h0001_2345);

        ins_in = 32'h0400_0002;
        step();
        chk_out("after_comm", 32'h0400_0002, 1'b1, 1'b0, 1'b0);
        chk("sig_hold", {13'd0, signal_out}, 32'h0001_2345);

        // opcode 0 with nonzero body is a normal instruction
        ins_in = 32'h0000_0001;
        step();
        chk_out("opc0", 32'h0000_0001, 1'b1, 1'b0, 1'b0);

        // wait in RUN freezes ins_out and drops enable
        wait_for_next_in = 1'b1;
        ins_in = 32'h0400_0006;
        step();
        chk_out("wait_run", 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        wait_for_next_in = 1'b0;

        // control flow followed by 4 bubbles
        ins_in = 32'h0800_0010;
        step();
        chk_out("ctrl", 32'h0800_0010, 1'b1, 1'b0, 1'b0);
        ins_in = 32'h0400_0003;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out($sformatf("bubble%0d", i), 32'h0, 1'b0, 1'b0,
                    i == 3);
        end
        step();
        chk_out("resume", 32'h0400_0003, 1'b1, 1'b0, 1'b0);

        // upper end of CTRL range, with a wait inside the stall
        ins_in = 32'h1C00_0020;
        step();
        chk_out("ctrl2", 32'h1C00_0020, 1'b1, 1'b0, 1'b0);
        ins_in = 32'hFC00_0077;
        step();
        chk_out("b2_0", 32'h0, 1'b0, 1'b0, 1'b0);
        wait_for_next_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("stall_wait%0d", i), 32'h0, 1'b0, 1'b0,
                    1'b0);
        end
        wait_for_next_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("b2_%0d", i + 1), 32'h0, 1'b0, 1'b0,
                    i == 2);
        end
        chk("stall_sig", {13'd0, signal_out}, 32'h0001_2345);

        // opcode just above CTRL range is normal
        ins_in = 32'h2000_0005;
        step();
        chk_out("opc08", 32'h2000_0005, 1'b1, 1'b0, 1'b0);

        // back-to-back COMM
        ins_in = 32'hFC00_0001;
        step();
        chk_out("comm_a", 32'h0, 1'b0, 1'b1, 1'b0);
        ins_in = 32'hFC07_FFFF;
        step();
        chk_out("comm_b", 32'h0, 1'b0, 1'b1, 1'b0);
        chk("comm_b.sig", {13'd0, signal_out}, 32'h0007_FFFF);
        ins_in = 32'h0000_0000;
        step();
        chk_out("comm_end", 32'h0, 1'b0, 1'b0, 1'b0);

        // reset during stall cancels the redirect
        ins_in = 32'h0800_0040;
        step();
        chk_out("ctrl3", 32'h0800_0040, 1'b1, 1'b0, 1'b0);
        ins_in = 32'h0000_0000;
        step();
        reset_n = 1'b0;
        #1;
        chk_out("rst_stall", 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_stall.sig", {13'd0, signal_out}, 32'h0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out($sformatf("post_rst%0d", i), 32'h0, 1'b0, 1'b0,
                    1'b0);
        end
        ins_in = 32'h0400_0009;
        step();
        chk_out("post_rst_run", 32'h0400_0009, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
